fetch_stage: RTL and testbench

- Instruction-fetch stage of the pipelined RV32I core, directly upstream of the decode/control unit.
- Owns the PC register and drives a pipelined instruction-memory port (request/grant, 1-cycle read latency).
- Buffers one returning word in a skid entry; presents the IF/ID register (instr, pc, pc+4, valid) to decode.
- Honours load-use stalls from hazard detection and PC redirects from EX (taken branch / JAL / JALR).

---
 rtl/fetch_stage_if.sv | 25 ++
 rtl/fetch_stage.sv | 176 +++++++++++++++++
 tb/tb_fetch_stage.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Bundle of the fetch stage's instruction-memory port, IF/ID outputs and hazard/redirect controls.
// The master side is the fetch stage; the slave side is memory, decode and the hazard/EX logic.
interface fetch_stage_if;
    logic        i_stall;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt;
    logic [31:0] i_imem_rdata;
    logic [31:0] o_id_instr;
    logic [31:0] o_id_pc;
    logic [31:0] o_id_pc4;
    logic        o_id_vld;

    modport master (
        input  i_stall, i_redirect, i_redirect_pc, i_imem_gnt, i_imem_rdata,
        output o_imem_req, o_imem_addr, o_id_instr, o_id_pc, o_id_pc4, o_id_vld
    );

    modport slave (
        output i_stall, i_redirect, i_redirect_pc, i_imem_gnt, i_imem_rdata,
        input  o_imem_req, o_imem_addr, o_id_instr, o_id_pc, o_id_pc4, o_id_vld
    );
endinterface

// File: rtl/fetch_stage.sv
// RV32I fetch stage: PC register, pipelined imem request/grant port, one-entry skid and IF/ID register.
// Define FETCH_PERF_EN to add the o_fetch_cnt / o_bubble_cnt performance counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
    input  logic          i_clk,
    input  logic          i_reset,
    fetch_stage_if.master bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]   o_fetch_cnt,
    output logic [31:0]   o_bubble_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        inflight_q, inflight_d;
    logic [31:0] inflight_pc_q, inflight_pc_d;
    logic        kill_q, kill_d;
    logic        skid_full_q, skid_full_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        id_vld_q, id_vld_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_pc4_q, id_pc4_d;

    logic imem_req;
    logic accept;
    logic rsp_live;

    // A stalled cycle that already has a word arriving (or parked in the skid) must not
    // launch another fetch, so at most one word ever sits beyond IF/ID.
    always_comb begin
        imem_req = (state_q == S_RUN) && !bus.i_redirect &&
                   !(bus.i_stall && ((inflight_q && !kill_q) || skid_full_q));
        accept   = imem_req && bus.i_imem_gnt;
        rsp_live = inflight_q && !kill_q && !bus.i_redirect;
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        kill_d        = kill_q;
        skid_full_d   = skid_full_q;
        skid_instr_d  = skid_instr_q;
        skid_pc_d     = skid_pc_q;
        id_vld_d      = id_vld_q;
        id_instr_d    = id_instr_q;
        id_pc_d       = id_pc_q;
        id_pc4_d      = id_pc4_q;

        if (accept) begin
            pc_d          = pc_q + 32'd4;
            inflight_d    = 1'b1;
            inflight_pc_d = pc_q;
            kill_d        = 1'b0;
        end

        if (bus.i_redirect) begin
            pc_d        = bus.i_redirect_pc & ~32'h3;
            kill_d      = 1'b1;
            skid_full_d = 1'b0;
            id_vld_d    = 1'b0;
            id_instr_d  = NOP_INSN;
        end else if (!bus.i_stall) begin
            if (skid_full_q) begin
                // Older skid word goes first; a live response takes its place.
                id_vld_d    = 1'b1;
                id_instr_d  = skid_instr_q;
                id_pc_d     = skid_pc_q;
                id_pc4_d    = skid_pc_q + 32'd4;
                skid_full_d = rsp_live;
                if (rsp_live) begin
                    skid_instr_d = bus.i_imem_rdata;
                    skid_pc_d    = inflight_pc_q;
                end
            end else if (rsp_live) begin
                id_vld_d   = 1'b1;
                id_instr_d = bus.i_imem_rdata;
                id_pc_d    = inflight_pc_q;
                id_pc4_d   = inflight_pc_q + 32'd4;
            end else begin
                id_vld_d   = 1'b0;
                id_instr_d = NOP_INSN;
            end
        end else if (rsp_live) begin
            skid_full_d  = 1'b1;
            skid_instr_d = bus.i_imem_rdata;
            skid_pc_d    = inflight_pc_q;
        end

        case (state_q)
            S_IDLE:  state_d = S_RUN;
            S_RUN:   if (skid_full_d) state_d = S_HOLD;
            S_HOLD:  if (!skid_full_d) state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
        if (bus.i_redirect) begin
            state_d = S_RUN;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'd0;
            kill_q        <= 1'b0;
            skid_full_q   <= 1'b0;
            skid_instr_q  <= NOP_INSN;
            skid_pc_q     <= 32'd0;
            id_vld_q      <= 1'b0;
            id_instr_q    <= NOP_INSN;
            id_pc_q       <= 32'd0;
            id_pc4_q      <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            kill_q        <= kill_d;
            skid_full_q   <= skid_full_d;
            skid_instr_q  <= skid_instr_d;
            skid_pc_q     <= skid_pc_d;
            id_vld_q      <= id_vld_d;
            id_instr_q    <= id_instr_d;
            id_pc_q       <= id_pc_d;
            id_pc4_q      <= id_pc4_d;
        end
    end

    assign bus.o_imem_req  = imem_req;
    assign bus.o_imem_addr = pc_q & ~32'h3;
    assign bus.o_id_instr  = id_instr_q;
    assign bus.o_id_pc     = id_pc_q;
    assign bus.o_id_pc4    = id_pc4_q;
    assign bus.o_id_vld    = id_vld_q;

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;
    logic        id_load;

    always_comb begin
        id_load      = !bus.i_redirect && !bus.i_stall && (skid_full_q || rsp_live);
        fetch_cnt_d  = fetch_cnt_q + {31'd0, id_load};
        bubble_cnt_d = bubble_cnt_q + {31'd0, (state_q != S_IDLE) && !id_vld_q};
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            fetch_cnt_q  <= 32'd0;
            bubble_cnt_q <= 32'd0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign o_fetch_cnt  = fetch_cnt_q;
    assign o_bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage; the memory model returns the fetch address as data.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    fetch_stage_if bus ();

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt;
    logic [31:0] bubble_cnt;
`endif

    fetch_stage dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus)
`ifdef FETCH_PERF_EN
        ,
        .o_fetch_cnt  (fetch_cnt),
        .o_bubble_cnt (bubble_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: one-cycle latency, data = address; garbage when nothing was accepted.
    always @(posedge clk) begin
        bus.i_imem_rdata <= (bus.o_imem_req && bus.i_imem_gnt) ? bus.o_imem_addr : 32'hDEAD_BEEF;
    end

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        gnt;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_pc;
    } vec_t;

    localparam int NVEC = 37;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic stall, input logic redir, input logic [31:0] rpc,
                                input logic gnt, input logic e_req, input logic [31:0] e_addr,
                                input logic e_vld, input logic [31:0] e_pc);
        vec_t v;
        v.stall = stall; v.redir = redir; v.rpc = rpc; v.gnt = gnt;
        v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld; v.e_pc = e_pc;
        return v;
    endfunction

    // Expected instruction follows from the memory model: valid words equal their PC, bubbles are NOP.
    task automatic check_cycle(input string name, input logic e_req, input logic [31:0] e_addr,
                               input logic e_vld, input logic [31:0] e_pc);
        logic        bad;
        logic [31:0] e_instr;
        e_instr = e_vld ? e_pc : NOP;
        checks++;
        bad = (bus.o_imem_req !== e_req) || (bus.o_id_vld !== e_vld) || (bus.o_id_instr !== e_instr);
        if (e_req)
            bad = bad || (bus.o_imem_addr !== e_addr);
        if (e_vld)
            bad = bad || (bus.o_id_pc !== e_pc) || (bus.o_id_pc4 !== e_pc + 32'd4);
        if (bad) begin
            errors++;
            $display("FAIL %s: got req=%0b addr=%h vld=%0b instr=%h pc=%h pc4=%h, expected req=%0b addr=%h vld=%0b instr=%h pc=%h",
                     name, bus.o_imem_req, bus.o_imem_addr, bus.o_id_vld, bus.o_id_instr,
                     bus.o_id_pc, bus.o_id_pc4, e_req, e_addr, e_vld, e_instr, e_pc);
        end else begin
            $display("ok   %s: req=%0b addr=%h vld=%0b instr=%h pc=%h",
                     name, bus.o_imem_req, bus.o_imem_addr, bus.o_id_vld, bus.o_id_instr, bus.o_id_pc);
        end
    endtask

    task automatic check_reset(input string name);
        checks++;
        if (bus.o_imem_req !== 1'b0 || bus.o_id_vld !== 1'b0 || bus.o_id_instr !== NOP ||
            bus.o_id_pc !== 32'd0 || bus.o_id_pc4 !== 32'd0) begin
            errors++;
            $display("FAIL %s: got req=%0b vld=%0b instr=%h pc=%h pc4=%h, expected req=0 vld=0 instr=%h pc=0 pc4=0",
                     name, bus.o_imem_req, bus.o_id_vld, bus.o_id_instr, bus.o_id_pc, bus.o_id_pc4, NOP);
        end else begin
            $display("ok   %s: reset values", name);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.i_stall       = 1'b0;
        bus.i_redirect    = 1'b0;
        bus.i_redirect_pc = 32'd0;
        bus.i_imem_gnt    = 1'b1;

        //             stall redir rpc           gnt  req addr          vld pc
        vecs[0]  = mk(0, 0, 32'h0,          1,  0, 32'h0,          0, 32'h0);
        vecs[1]  = mk(0, 0, 32'h0,          1,  1, 32'h0,          0, 32'h0);
        vecs[2]  = mk(0, 0, 32'h0,          1,  1, 32'h4,          0, 32'h0);
        vecs[3]  = mk(0, 0, 32'h0,          1,  1, 32'h8,          1, 32'h0);
        vecs[4]  = mk(0, 0, 32'h0,          1,  1, 32'hC,          1, 32'h4);
        vecs[5]  = mk(0, 0, 32'h0,          1,  1, 32'h10,         1, 32'h8);
        vecs[6]  = mk(0, 0, 32'h0,          1,  1, 32'h14,         1, 32'hC);
        vecs[7]  = mk(1, 0, 32'h0,          1,  0, 32'h18,         1, 32'h10);
        vecs[8]  = mk(1, 0, 32'h0,          1,  0, 32'h18,         1, 32'h10);
        vecs[9]  = mk(1, 0, 32'h0,          1,  0, 32'h18,         1, 32'h10);
        vecs[10] = mk(0, 0, 32'h0,          1,  0, 32'h18,         1, 32'h10);
        vecs[11] = mk(0, 0, 32'h0,          1,  1, 32'h18,         1, 32'h14);
        vecs[12] = mk(0, 0, 32'h0,          1,  1, 32'h1C,         0, 32'h0);
        vecs[13] = mk(0, 0, 32'h0,          1,  1, 32'h20,         1, 32'h18);
        vecs[14] = mk(0, 1, 32'h200,        1,  0, 32'h0,          1, 32'h1C);
        vecs[15] = mk(0, 0, 32'h0,          1,  1, 32'h200,        0, 32'h0);
        vecs[16] = mk(0, 0, 32'h0,          1,  1, 32'h204,        0, 32'h0);
        vecs[17] = mk(0, 0, 32'h0,          1,  1, 32'h208,        1, 32'h200);
        vecs[18] = mk(1, 1, 32'h303,        1,  0, 32'h0,          1, 32'h204);
        vecs[19] = mk(0, 0, 32'h0,          1,  1, 32'h300,        0, 32'h0);
        vecs[20] = mk(0, 0, 32'h0,          1,  1, 32'h304,        0, 32'h0);
        vecs[21] = mk(0, 0, 32'h0,          1,  1, 32'h308,        1, 32'h300);
        vecs[22] = mk(0, 1, 32'h40,         1,  0, 32'h0,          1, 32'h304);
        for (int i = 23; i <= 27; i++)
            vecs[i] = mk(0, 0, 32'h0,       0,  1, 32'h40,         0, 32'h0);
        vecs[28] = mk(0, 0, 32'h0,          1,  1, 32'h40,         0, 32'h0);
        vecs[29] = mk(0, 0, 32'h0,          1,  1, 32'h44,         0, 32'h0);
        vecs[30] = mk(0, 0, 32'h0,          1,  1, 32'h48,         1, 32'h40);
        vecs[31] = mk(0, 1, 32'hFFFF_FFF8,  1,  0, 32'h0,          1, 32'h44);
        vecs[32] = mk(0, 0, 32'h0,          1,  1, 32'hFFFF_FFF8,  0, 32'h0);
        vecs[33] = mk(0, 0, 32'h0,          1,  1, 32'hFFFF_FFFC,  0, 32'h0);
        vecs[34] = mk(0, 0, 32'h0,          1,  1, 32'h0,          1, 32'hFFFF_FFF8);
        vecs[35] = mk(0, 0, 32'h0,          1,  1, 32'h4,          1, 32'hFFFF_FFFC);
        vecs[36] = mk(0, 0, 32'h0,          1,  1, 32'h8,          1, 32'h0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 check_reset("reset_hold");

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NVEC; i++) begin
            if (i != 0) @(negedge clk);
            bus.i_stall       = vecs[i].stall;
            bus.i_redirect    = vecs[i].redir;
            bus.i_redirect_pc = vecs[i].rpc;
            bus.i_imem_gnt    = vecs[i].gnt;
            #1 check_cycle($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr,
                           vecs[i].e_vld, vecs[i].e_pc);
        end

        // Asynchronous reset in the middle of a stream, with a word in flight.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset("async_reset_mid_stream");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_cycle("restart_c0", 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        #1 check_cycle("restart_c1", 1'b1, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        #1 check_cycle("restart_c2", 1'b1, 32'h4, 1'b0, 32'h0);
        @(negedge clk);
        #1 check_cycle("restart_c3", 1'b1, 32'h8, 1'b1, 32'h0);
        @(negedge clk);
        #1 check_cycle("restart_c4", 1'b1, 32'hC, 1'b1, 32'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete, expected finish before 20000");
        $fatal(1, "timeout");
    end

endmodule
